// File: rtl/mac4b_issue_scheduler.sv
// Buffers MAC4B instructions until the core commits or kills them, then runs the
// shared mac4b datapath one committed instruction at a time, returning results in issue order.
module mac4b_issue_scheduler #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [4:0]          issue_rd_i,
  input  logic [31:0]         issue_rs1_i,
  input  logic [31:0]         issue_rs2_i,
  input  logic [31:0]         issue_rs3_i,
  input  logic                issue_acc_i,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic [31:0]         mac_rs1_o,
  output logic [31:0]         mac_rs2_o,
  output logic [31:0]         mac_acc_o,
  input  logic [31:0]         mac_sum_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [4:0]          result_rd_o,
  output logic [31:0]         result_data_o,
  output logic                result_we_o,
  output logic                busy_o,
  output logic [1:0]          dbg_state_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ID_WIDTH-1:0] id_q  [DEPTH];
  logic [4:0]          rd_q  [DEPTH];
  logic [31:0]         rs1_q [DEPTH];
  logic [31:0]         rs2_q [DEPTH];
  logic [31:0]         acc_q [DEPTH];
  logic [DEPTH-1:0]    valid_q, committed_q, killed_q;
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    count_q;

  logic [ID_WIDTH-1:0] result_id_q;
  logic [4:0]          result_rd_q;
  logic [31:0]         result_data_q;

  logic push, pop, capture, head_valid, commit_hits_incoming;

  // Handshakes: a transfer happens on a clock edge where both valid and ready are high;
  // valid is never withdrawn and payload never changes while waiting for ready.
  assign issue_ready_o        = (count_q < CNT_W'(DEPTH));
  assign push                 = issue_valid_i & issue_ready_o;
  assign head_valid           = valid_q[head_q];
  assign commit_hits_incoming = commit_valid_i & (commit_id_i == issue_id_i);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (head_valid && killed_q[head_q]) begin
          pop = 1'b1;
        end else if (head_valid && committed_q[head_q]) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        pop     = 1'b1;
        capture = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (result_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control side of the queue; the commit scan runs first so a push or pop on the
  // same slot in the same cycle takes precedence.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q     <= '0;
      committed_q <= '0;
      killed_q    <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      if (commit_valid_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_q[i] && (id_q[i] == commit_id_i) && !committed_q[i] && !killed_q[i]) begin
            if (commit_kill_i) killed_q[i] <= 1'b1;
            else               committed_q[i] <= 1'b1;
          end
        end
      end
      if (push) begin
        valid_q[tail_q]     <= 1'b1;
        committed_q[tail_q] <= commit_hits_incoming & ~commit_kill_i;
        killed_q[tail_q]    <= commit_hits_incoming & commit_kill_i;
        tail_q              <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        valid_q[head_q]     <= 1'b0;
        committed_q[head_q] <= 1'b0;
        killed_q[head_q]    <= 1'b0;
        head_q              <= head_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload storage needs no reset: a slot is only read while its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[tail_q]  <= issue_id_i;
      rd_q[tail_q]  <= issue_rd_i;
      rs1_q[tail_q] <= issue_rs1_i;
      rs2_q[tail_q] <= issue_rs2_i;
      acc_q[tail_q] <= issue_acc_i ? issue_rs3_i : 32'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      result_id_q   <= '0;
      result_rd_q   <= '0;
      result_data_q <= '0;
    end else if (capture) begin
      result_id_q   <= id_q[head_q];
      result_rd_q   <= rd_q[head_q];
      result_data_q <= mac_sum_i;
    end
  end

  assign mac_rs1_o      = head_valid ? rs1_q[head_q] : 32'd0;
  assign mac_rs2_o      = head_valid ? rs2_q[head_q] : 32'd0;
  assign mac_acc_o      = head_valid ? acc_q[head_q] : 32'd0;

  assign result_valid_o = (state_q == S_RESP);
  assign result_we_o    = result_valid_o;
  assign result_id_o    = result_id_q;
  assign result_rd_o    = result_rd_q;
  assign result_data_o  = result_data_q;
  assign busy_o         = (count_q != '0) || (state_q != S_IDLE);
  assign dbg_state_o    = state_q;

endmodule
